// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
// The sat_reduce helper is only referenced when FIR_SEQ_SATURATE_EN is defined.
package fir_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // Default coefficient fraction bits and tap count.
  localparam int DEF_FRAC  = 14;
  localparam int DEF_NTAPS = 8;

  // Working width of the clamp helper; wide enough for any legal accumulator.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             clamped;
    logic [SAT_W-1:0] value;
  } sat_res_t;

  // Clamp a sign-extended accumulator value into the signed range of data_w bits.
  function automatic sat_res_t sat_reduce(input logic signed [SAT_W-1:0] v,
                                          input int unsigned data_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    hi        = $signed((SAT_W'(1) << (data_w - 1)) - SAT_W'(1));
    lo        = ~hi;
    r.clamped = 1'b0;
    r.value   = v;
    if (v > hi) begin
      r.clamped = 1'b1;
      r.value   = hi;
    end else if (v < lo) begin
      r.clamped = 1'b1;
      r.value   = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history for the FIR sequencer: NTAPS registers, one write
// port, one combinational read index, all entries cleared by reset.
module fir_delay_line #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(NTAPS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NTAPS)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [NTAPS];

  // Sample storage: cleared on reset, one entry written per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one shared signed multiplier and accumulator
// walk NTAPS coefficients per accepted sample, then the sum is rescaled by FRAC.
// Optional feature macro FIR_SEQ_SATURATE_EN: clamp instead of wrap on the
// final reduction and expose sat_flag.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = DEF_FRAC,
  parameter int NTAPS  = DEF_NTAPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_sample,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_drop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_sample,
  output logic                     busy
`ifdef FIR_SEQ_SATURATE_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  // Headroom of log2(NTAPS) bits means the sum of NTAPS full products cannot overflow.
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);

  localparam logic [AW-1:0]     K_LAST   = AW'(NTAPS - 1);
  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC;

  state_e                   state_q, state_d;
  logic [AW-1:0]            k_q, k_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_sample_q, out_sample_d;
  logic                     coef_drop_q, coef_drop_d;
  logic [COEF_W-1:0]        coef_q [NTAPS];

  logic                     dl_we;
  logic                     coef_wr_en;
  logic [AW-1:0]            rd_idx;
  logic [DATA_W-1:0]        x_rd;
  logic [COEF_W-1:0]        coef_k;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [DATA_W-1:0]        reduced;

`ifdef FIR_SEQ_SATURATE_EN
  logic                     sat_q, sat_d;
  logic                     clamped;
  logic signed [ACC_W-1:0]  acc_shift;
  sat_res_t                 sat_res;
`endif

  fir_delay_line #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (dl_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_sample),
    .raddr_i (rd_idx),
    .rdata_o (x_rd)
  );

  // Newest sample sits at wr_ptr during MAC, so tap k looks k entries back.
  assign rd_idx   = wr_ptr_q - k_q;
  assign coef_k   = coef_q[k_q];
  assign coef_ext = {{DATA_W{coef_k[COEF_W-1]}}, coef_k};
  assign x_ext    = {{COEF_W{x_rd[DATA_W-1]}}, x_rd};
  assign prod     = coef_ext * x_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Coefficient writes only land while idle; anything else is reported as dropped.
  assign coef_wr_en  = coef_we && (state_q == S_IDLE);
  assign coef_drop_d = coef_we && (state_q != S_IDLE);

`ifdef FIR_SEQ_SATURATE_EN
  assign acc_shift = acc_q >>> FRAC;
  assign sat_res   = sat_reduce({{(SAT_W-ACC_W){acc_shift[ACC_W-1]}}, acc_shift}, DATA_W);
  assign reduced   = DATA_W'(sat_res.value);
  assign clamped   = sat_res.clamped;
`else
  // Arithmetic shift floors toward -inf; the size cast wraps to DATA_W.
  assign reduced = DATA_W'(acc_q >>> FRAC);
`endif

  // Coefficient bank: unity passthrough on tap 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else if (coef_wr_en) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Next-state, datapath update and delay-line write enable.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wr_ptr_d     = wr_ptr_q;
    acc_d        = acc_q;
    out_sample_d = out_sample_q;
    dl_we        = 1'b0;
`ifdef FIR_SEQ_SATURATE_EN
    sat_d        = sat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dl_we   = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = S_SCALE;
        end
      end
      S_SCALE: begin
        out_sample_d = reduced;
`ifdef FIR_SEQ_SATURATE_EN
        sat_d        = clamped;
`endif
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      acc_q        <= '0;
      out_sample_q <= '0;
      coef_drop_q  <= 1'b0;
`ifdef FIR_SEQ_SATURATE_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wr_ptr_q     <= wr_ptr_d;
      acc_q        <= acc_d;
      out_sample_q <= out_sample_d;
      coef_drop_q  <= coef_drop_d;
`ifdef FIR_SEQ_SATURATE_EN
      sat_q        <= sat_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign out_sample = out_sample_q;
  assign coef_drop  = coef_drop_q;
`ifdef FIR_SEQ_SATURATE_EN
  assign sat_flag   = sat_q;
`endif

endmodule
